// File: rtl/ssd_scan.sv
// Multiplexed seven-segment scanner: latches one nibble per digit and rotates the
// digits onto a shared active-low segment bus with rotating active-low anodes.
module ssd_scan #(
  parameter  int DIGITS      = 4,
  parameter  int REFRESH_DIV = 100000,
  localparam int SEL_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int RC_W        = $clog2(REFRESH_DIV)
) (
  input  logic              ssd_scan_clk,
  input  logic              ssd_scan_rst,
  input  logic              ssd_scan_en,
  input  logic              ssd_scan_ld,
  input  logic [SEL_W-1:0]  ssd_scan_digit_sel,
  input  logic [3:0]        ssd_scan_d,
  input  logic              ssd_scan_mode,
  input  logic              ssd_scan_blank_lz,
  output logic [DIGITS-1:0] ssd_scan_an,
  output logic [6:0]        ssd_scan_seg
);

  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] digit_w;
  logic [DIGITS-1:0]      zero_w;
  logic [DIGITS-1:0]      lz_w;
  logic [RC_W-1:0]        rcnt_q, rcnt_d;
  logic [SEL_W-1:0]       idx_q, idx_d;
  logic [3:0]             cur_w;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_seg = 7'h40;
      4'h1:    hex_seg = 7'h79;
      4'h2:    hex_seg = 7'h24;
      4'h3:    hex_seg = 7'h30;
      4'h4:    hex_seg = 7'h19;
      4'h5:    hex_seg = 7'h12;
      4'h6:    hex_seg = 7'h02;
      4'h7:    hex_seg = 7'h78;
      4'h8:    hex_seg = 7'h00;
      4'h9:    hex_seg = 7'h10;
      4'hA:    hex_seg = 7'h08;
      4'hB:    hex_seg = 7'h03;
      4'hC:    hex_seg = 7'h46;
      4'hD:    hex_seg = 7'h21;
      4'hE:    hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Refresh counter and scan index only advance while the display is enabled.
  always_comb begin
    rcnt_d = rcnt_q;
    idx_d  = idx_q;
    if (ssd_scan_en) begin
      if (rcnt_q == RC_LAST) begin
        rcnt_d = '0;
        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1);
      end else begin
        rcnt_d = rcnt_q + RC_W'(1);
      end
    end
  end

  always_ff @(posedge ssd_scan_clk or posedge ssd_scan_rst) begin
    if (ssd_scan_rst) begin
      rcnt_q <= '0;
      idx_q  <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
    end
  end

  // Equality decode means an out-of-range select matches no digit and is dropped.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] val_q;

    always_ff @(posedge ssd_scan_clk or posedge ssd_scan_rst) begin
      if (ssd_scan_rst) begin
        val_q <= '0;
      end else if (ssd_scan_ld && (ssd_scan_digit_sel == SEL_W'(gi))) begin
        val_q <= ssd_scan_d;
      end
    end

    assign digit_w[gi] = val_q;
    assign zero_w[gi]  = (val_q == 4'h0);
    // lz_w[gi]: this digit and every more significant one hold zero.
    assign lz_w[gi]    = &zero_w[DIGITS-1:gi];
  end

  assign cur_w = digit_w[idx_q];

  always_comb begin
    ssd_scan_an  = '1;
    ssd_scan_seg = 7'h7F;
    if (ssd_scan_en) begin
      ssd_scan_an = ~(DIGITS'(1) << idx_q);
      if (ssd_scan_blank_lz && (idx_q != '0) && lz_w[idx_q]) begin
        ssd_scan_seg = 7'h7F;
      end else if (ssd_scan_mode && (cur_w > 4'd9)) begin
        ssd_scan_seg = 7'h3F;
      end else begin
        ssd_scan_seg = hex_seg(cur_w);
      end
    end
  end

endmodule
